decap_packet: RTL
=================

Name: decap_packet

Overview:
- Receive-side counterpart of the transmit encapsulator. Sits directly downstream of the Aurora RX user interface.
- Takes a burst of 64-bit beats, each carrying a constant per-packet header plus a payload slice, and reassembles the full DFX word (data + address).
- Presents the result and its header to the input-port logic with a one-cycle done pulse.
- Detects header inconsistency across beats and inter-beat timeouts.

Parameters:
- DATA_WIDTH, 1024, user data bits in a DFX word
- ADDR_WIDTH, 10, address bits appended above the data
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), reassembled word width
- RECOGNIZE_ROUTER_WIDTH, 2, router-ID field width
- NUMBER_PACKET, 19, beats per DFX word
- TTL_WIDTH, $clog2(3) (2), TTL field width
- HEADER_WIDTH, RECOGNIZE_ROUTER_WIDTH+$clog2(NUMBER_PACKET)+TTL_WIDTH (9), header width
- AURORA_DATA_WIDTH, 64, beat width
- PAYLOAD_WIDTH, AURORA_DATA_WIDTH-HEADER_WIDTH (55), payload bits per beat
- TIMEOUT_CYCLES, 64, maximum idle cycles between beats inside a packet

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_recv  input  AURORA_DATA_WIDTH  received beat; header in [HEADER_WIDTH-1:0], payload in [63:HEADER_WIDTH]
- data_recv_valid  input  1  beat qualifier; one beat accepted per cycle while high
- data_dfx_recv  output  DATA_DFX_WIDTH  reassembled DFX word
- header_pkt_recv  output  HEADER_WIDTH  header of the reassembled word
- decap_done  output  1  one-cycle pulse; both outputs above are valid
- decap_err  output  1  one-cycle pulse; the packet in progress was aborted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, beat counter 0, state IDLE, assembly buffer 0, timeout counter 0.
- Wire format, beat k for k=0..17: payload carries word bits [k*55 +: 55].
- Wire format, beat 18: data_recv[52:9] carries word bits [1033:990] (44 bits); data_recv[63:53] must be 0 and is ignored on receive.
- State IDLE:
  - On valid, capture the header into a reference register and write payload slice 0.
  - Set counter to 1 and go to COLLECT.
- State COLLECT, valid with header equal to the reference:
  - Write slice[counter] and increment the counter.
  - If counter==18: write the final 44 bits, go to IDLE, clear the counter.
  - On the next clock edge, data_dfx_recv is updated from the buffer, header_pkt_recv is updated from the reference, and decap_done=1 for exactly one cycle.
  - Latency: done asserts 1 cycle after the 19th beat is sampled.
- State COLLECT, valid with header not equal to the reference:
  - Abort. Pulse decap_err for one cycle.
  - Treat the offending beat as beat 0 of a new packet: recapture the reference, write slice 0, set counter to 1, stay in COLLECT.
- State COLLECT, valid low:
  - Hold the counter and increment the timeout counter.
  - When the timeout counter reaches TIMEOUT_CYCLES: pulse decap_err, go to IDLE, clear the counters.
  - Any accepted beat clears the timeout counter.
- Back-to-back packets: a valid beat in the cycle after the 19th beat starts a new packet in IDLE with no bubble.
- Output holding: decap_done and decap_err are never high in the same cycle. data_dfx_recv and header_pkt_recv hold their last completed value until the next done; they are not cleared when a packet aborts.
- Buffer contents: the buffer is not cleared between packets. Every slice is rewritten before each done, so stale data cannot leak.
- Reset mid-packet: all state is lost and no done or err is issued. The next valid beat is treated as beat 0.
- No backpressure: the block always accepts beats.

Decomposition:
- Shared package:
  - Header field widths and offsets (ROUTER_ID [1:0], PKT_IDX [6:2], TTL [8:7]).
  - PAYLOAD_WIDTH, NUMBER_PACKET, LAST_BEAT_BITS=44.
  - State encoding (IDLE, COLLECT); the transmit encapsulator uses the same package.
- Sub-module: one, decap_timeout_counter. It takes a clear and an enable and flags expiry; the same counter is reusable elsewhere on the link.

Test Plan:
- Single packet: 19 consecutive valid beats, header 9'h0A5, word = incrementing byte pattern -> decap_done pulses 1 cycle after beat 18, data_dfx_recv equals the pattern bit-exact, header_pkt_recv=9'h0A5, decap_err stays 0.
- Gaps: same packet with valid low for 10 cycles after beats 3 and 12 -> identical result, done 1 cycle after the last beat, no err.
- Header mismatch: beats 0..6 with header 9'h011, then 19 beats with header 9'h022 -> decap_err pulses 1 cycle after beat 7; a single done follows with header 9'h022 and the second packet's data.
- Timeout: 5 beats, then valid low for 64 cycles -> decap_err pulses once, state returns to IDLE; a following complete packet completes normally.
- Back-to-back: two 19-beat packets with no gap -> two done pulses exactly 19 cycles apart, each with the correct data.
- Reset mid-packet: rst_n low during beat 9, then a full packet -> no err, one done with the new data; all outputs read 0 while in reset.

Source files
------------

// File: rtl/decap_pkg.sv
// Shared definitions for the Aurora encapsulation/decapsulation link.
// Header layout: ROUTER_ID [1:0], PKT_IDX [6:2], TTL [8:7].
package decap_pkg;

   localparam int DATA_WIDTH             = 1024;
   localparam int ADDR_WIDTH             = 10;
   localparam int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH;
   localparam int RECOGNIZE_ROUTER_WIDTH = 2;
   localparam int NUMBER_PACKET          = 19;
   localparam int TTL_WIDTH              = $clog2(3);
   localparam int IDX_WIDTH              = $clog2(NUMBER_PACKET);
   localparam int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + IDX_WIDTH + TTL_WIDTH;
   localparam int AURORA_DATA_WIDTH      = 64;
   localparam int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH;
   localparam int TIMEOUT_CYCLES         = 64;
   localparam int LAST_BEAT_BITS         = DATA_DFX_WIDTH - (NUMBER_PACKET - 1) * PAYLOAD_WIDTH;

   localparam int ROUTER_ID_LSB = 0;
   localparam int PKT_IDX_LSB   = ROUTER_ID_LSB + RECOGNIZE_ROUTER_WIDTH;
   localparam int TTL_LSB       = PKT_IDX_LSB + IDX_WIDTH;

   typedef logic [HEADER_WIDTH-1:0] header_t;

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   function automatic header_t header_of(input logic [AURORA_DATA_WIDTH-1:0] beat);
      return beat[HEADER_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/decap_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles and flags the LIMIT-th one.
// Expiry also restarts the count so a single pulse is produced.
module decap_timeout_counter #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT);

   logic [CW-1:0] count;

   assign expired = enable && (count == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || expired) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/decap_packet.sv
// Reassembles 19 Aurora beats into one DFX word, checking header consistency
// across beats and aborting on header change or inter-beat timeout.
module decap_packet
   import decap_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
   input  logic                         data_recv_valid,
   output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
   output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
   output logic                         decap_done,
   output logic                         decap_err
);

   localparam int LOW_BITS = DATA_DFX_WIDTH - LAST_BEAT_BITS;

   state_t                    state;
   logic [IDX_WIDTH-1:0]      cnt;
   header_t                   ref_hdr;
   logic [DATA_DFX_WIDTH-1:0] buf_q;

   header_t                   hdr;
   logic [PAYLOAD_WIDTH-1:0]  payload;
   logic [LAST_BEAT_BITS-1:0] tail;
   logic                      hdr_match;
   logic                      last_beat;
   logic                      to_clear;
   logic                      to_enable;
   logic                      expired;
   logic                      wr_en;
   logic [IDX_WIDTH-1:0]      wr_idx;

   assign hdr       = header_of(data_recv);
   assign payload   = data_recv[AURORA_DATA_WIDTH-1:HEADER_WIDTH];
   assign tail      = data_recv[HEADER_WIDTH +: LAST_BEAT_BITS];
   assign hdr_match = (hdr == ref_hdr);
   assign last_beat = (cnt == IDX_WIDTH'(NUMBER_PACKET - 1));
   assign to_clear  = data_recv_valid || (state == IDLE);
   assign to_enable = (state == COLLECT) && !data_recv_valid;

   decap_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (to_clear),
      .enable  (to_enable),
      .expired (expired)
   );

   // A beat opening a packet (from IDLE or after a header change) lands in slice 0.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = '0;
      if (data_recv_valid) begin
         wr_en = 1'b1;
         if (state == COLLECT && hdr_match) begin
            wr_idx = cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         ref_hdr         <= '0;
         buf_q           <= '0;
         data_dfx_recv   <= '0;
         header_pkt_recv <= '0;
         decap_done      <= 1'b0;
         decap_err       <= 1'b0;
      end else begin
         decap_done <= 1'b0;
         decap_err  <= 1'b0;
         for (int i = 0; i < NUMBER_PACKET - 1; i++) begin
            if (wr_en && wr_idx == IDX_WIDTH'(i)) begin
               buf_q[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= payload;
            end
         end
         unique case (state)
            IDLE: begin
               if (data_recv_valid) begin
                  ref_hdr <= hdr;
                  cnt     <= IDX_WIDTH'(1);
                  state   <= COLLECT;
               end
            end
            COLLECT: begin
               if (data_recv_valid) begin
                  if (hdr_match) begin
                     if (last_beat) begin
                        buf_q[DATA_DFX_WIDTH-1 -: LAST_BEAT_BITS] <= tail;
                        data_dfx_recv   <= {tail, buf_q[LOW_BITS-1:0]};
                        header_pkt_recv <= ref_hdr;
                        decap_done      <= 1'b1;
                        cnt             <= '0;
                        state           <= IDLE;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     decap_err <= 1'b1;
                     ref_hdr   <= hdr;
                     cnt       <= IDX_WIDTH'(1);
                  end
               end else if (expired) begin
                  decap_err <= 1'b1;
                  cnt       <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
